// File: rtl/point_seq_reader.sv
// rtl/point_seq_reader.sv - streams an 8-point edge-normal probe bundle as clamped integer pixels
module point_seq_reader #(
    parameter int width = 10,
    parameter int FRAC  = 4,
    parameter int XMAX  = 39,
    parameter int YMAX  = 29
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [width*4-1:0]    new_xi,
    input  logic [width*4-1:0]    new_yi,
    input  logic [width*4-1:0]    new_xo,
    input  logic [width*4-1:0]    new_yo,
    output logic                  pt_valid,
    input  logic                  pt_ready,
    output logic [width-FRAC-1:0] pt_x,
    output logic [width-FRAC-1:0] pt_y,
    output logic [2:0]            pt_idx,
    output logic                  pt_oob,
    output logic                  pt_last,
    output logic                  done
);

    localparam int IW = width - FRAC;
    localparam logic [IW-1:0] XMAX_I = IW'(XMAX);
    localparam logic [IW-1:0] YMAX_I = IW'(YMAX);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [width*4-1:0]   r_xi, r_yi, r_xo, r_yo;
    logic [2:0]           r_idx;
    logic [IW-1:0]        r_pt_x, r_pt_y;
    logic                 r_pt_oob, r_pt_last, r_done;

    logic                 w_load, w_hs;
    logic [2:0]           w_nidx;
    logic [1:0]           w_lane;
    logic [width*4-1:0]   w_bx, w_by;
    logic [width-1:0]     w_fx, w_fy;
    logic [IW-1:0]        w_ix, w_iy;
    logic                 w_ox, w_oy;

    // flush wins over both the load and the point handshake
    assign w_load = ld_valid && (r_state == IDLE) && !flush;
    assign w_hs   = pt_ready && (r_state == EMIT) && !flush;

    always_comb begin
        w_state_nxt = r_state;
        ld_ready    = 1'b0;
        pt_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                ld_ready = 1'b1;
                if (w_load) w_state_nxt = EMIT;
            end
            EMIT: begin
                pt_valid = 1'b1;
                if (flush) w_state_nxt = IDLE;
                else if (w_hs && r_idx == 3'd7) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Point about to be presented: idx 0 of the incoming bundle on load, else idx+1 of the captured one.
    // Inner lanes run 3..0 (lane = ~idx), outer lanes run 0..3 (lane = idx-4).
    assign w_nidx = w_load ? 3'd0 : r_idx + 3'd1;
    assign w_lane = w_nidx[2] ? w_nidx[1:0] : ~w_nidx[1:0];
    assign w_bx   = w_nidx[2] ? (w_load ? new_xo : r_xo) : (w_load ? new_xi : r_xi);
    assign w_by   = w_nidx[2] ? (w_load ? new_yo : r_yo) : (w_load ? new_yi : r_yi);

    always_comb begin
        w_fx = '0;
        w_fy = '0;
        for (int k = 0; k < 4; k++) begin
            if (w_lane == 2'(k)) begin
                w_fx = w_bx[k*width +: width];
                w_fy = w_by[k*width +: width];
            end
        end
    end

    assign w_ix = w_fx[width-1:FRAC];
    assign w_iy = w_fy[width-1:FRAC];
    assign w_ox = w_ix > XMAX_I;
    assign w_oy = w_iy > YMAX_I;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xi      <= '0;
            r_yi      <= '0;
            r_xo      <= '0;
            r_yo      <= '0;
            r_idx     <= '0;
            r_pt_x    <= '0;
            r_pt_y    <= '0;
            r_pt_oob  <= 1'b0;
            r_pt_last <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == EMIT && flush) begin
                r_idx     <= '0;
                r_pt_x    <= '0;
                r_pt_y    <= '0;
                r_pt_oob  <= 1'b0;
                r_pt_last <= 1'b0;
            end else if (w_hs && r_idx == 3'd7) begin
                r_idx     <= '0;
                r_pt_x    <= '0;
                r_pt_y    <= '0;
                r_pt_oob  <= 1'b0;
                r_pt_last <= 1'b0;
                r_done    <= 1'b1;
            end else if (w_load || w_hs) begin
                if (w_load) begin
                    r_xi <= new_xi;
                    r_yi <= new_yi;
                    r_xo <= new_xo;
                    r_yo <= new_yo;
                end
                r_idx     <= w_nidx;
                r_pt_x    <= w_ox ? XMAX_I : w_ix;
                r_pt_y    <= w_oy ? YMAX_I : w_iy;
                r_pt_oob  <= w_ox || w_oy;
                r_pt_last <= (w_nidx == 3'd7);
            end
        end
    end

    assign pt_x    = r_pt_x;
    assign pt_y    = r_pt_y;
    assign pt_idx  = r_idx;
    assign pt_oob  = r_pt_oob;
    assign pt_last = r_pt_last;
    assign done    = r_done;

endmodule

// File: tb/tb_point_seq_reader.sv
// tb/tb_point_seq_reader.sv - directed self-checking bench for point_seq_reader
module tb_point_seq_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [39:0] new_xi = '0, new_yi = '0, new_xo = '0, new_yo = '0;
    logic        pt_valid;
    logic        pt_ready = 1'b0;
    logic [5:0]  pt_x, pt_y;
    logic [2:0]  pt_idx;
    logic        pt_oob, pt_last, done;

    int checks = 0;
    int errors = 0;

    logic [39:0] bxi[3], byi[3], bxo[3], byo[3];
    logic [5:0]  exp_x[3][8], exp_y[3][8];
    logic        exp_o[3][8];

    point_seq_reader #(.width(10), .FRAC(4), .XMAX(39), .YMAX(29)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .new_xi(new_xi), .new_yi(new_yi), .new_xo(new_xo), .new_yo(new_yo),
        .pt_valid(pt_valid), .pt_ready(pt_ready),
        .pt_x(pt_x), .pt_y(pt_y), .pt_idx(pt_idx),
        .pt_oob(pt_oob), .pt_last(pt_last), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_tables();
        int ax[8] = '{4, 7, 10, 13, 19, 22, 25, 28};
        int cx[8] = '{18, 3, 2, 1, 5, 6, 7, 39};
        bxi[0] = {10'h040, 10'h070, 10'h0A0, 10'h0D0};
        byi[0] = {4{10'h050}};
        bxo[0] = {10'h1C0, 10'h190, 10'h160, 10'h130};
        byo[0] = {4{10'h050}};
        bxi[1] = bxi[0];
        byi[1] = byi[0];
        bxo[1] = {10'h3F0, 10'h190, 10'h160, 10'h130};
        byo[1] = {10'h1F8, 10'h050, 10'h050, 10'h050};
        bxi[2] = {10'h120, 10'h030, 10'h020, 10'h010};
        byi[2] = {4{10'h100}};
        bxo[2] = {10'h27F, 10'h070, 10'h060, 10'h050};
        byo[2] = {4{10'h1D0}};
        for (int i = 0; i < 8; i++) begin
            exp_x[0][i] = 6'(ax[i]);  exp_y[0][i] = 6'd5; exp_o[0][i] = 1'b0;
            exp_x[1][i] = 6'(ax[i]);  exp_y[1][i] = 6'd5; exp_o[1][i] = 1'b0;
            exp_x[2][i] = 6'(cx[i]);  exp_y[2][i] = (i < 4) ? 6'd16 : 6'd29; exp_o[2][i] = 1'b0;
        end
        exp_x[1][7] = 6'd39; exp_y[1][7] = 6'd29; exp_o[1][7] = 1'b1;
    endtask

    task automatic apply(input int b);
        new_xi = bxi[b]; new_yi = byi[b]; new_xo = bxo[b]; new_yo = byo[b];
    endtask

    // Offers bundle b until accepted; leaves ld_valid high when keep is set.
    task automatic do_load(input int b, input bit keep);
        bit acc = 0;
        int n = 0;
        apply(b);
        ld_valid = 1'b1;
        while (!acc && n < 50) begin
            acc = ld_ready && !flush;
            tick();
            n++;
        end
        if (!keep) ld_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL load_timeout bundle %0d: not accepted within %0d cycles", b, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (pt_valid !== 1'b0 || pt_x !== 6'd0 || pt_y !== 6'd0 || pt_idx !== 3'd0 ||
            pt_oob !== 1'b0 || pt_last !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b x=%0d y=%0d idx=%0d oob=%b last=%b done=%b required all 0",
                     pt_valid, pt_x, pt_y, pt_idx, pt_oob, pt_last, done);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (ld_ready !== 1'b1 || pt_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ld_ready=%b valid=%b done=%b required 1 0 0", ld_ready, pt_valid, done);
        end
    endtask

    task automatic test_stream(input int b);
        pt_ready = 1'b1;
        do_load(b, 0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (pt_valid !== 1'b1 || pt_idx !== 3'(i) || pt_x !== exp_x[b][i] || pt_y !== exp_y[b][i] ||
                pt_oob !== exp_o[b][i] || pt_last !== (i == 7) || done !== 1'b0 || ld_ready !== 1'b0) begin
                errors++;
                $display("FAIL stream%0d_pt%0d: valid=%b idx=%0d x=%0d y=%0d oob=%b last=%b done=%b ldr=%b required 1 %0d %0d %0d %b %b 0 0",
                         b, i, pt_valid, pt_idx, pt_x, pt_y, pt_oob, pt_last, done, ld_ready,
                         i, exp_x[b][i], exp_y[b][i], exp_o[b][i], i == 7);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || pt_valid !== 1'b0 || ld_ready !== 1'b1 || pt_last !== 1'b0) begin
            errors++;
            $display("FAIL stream%0d_done: done=%b valid=%b ld_ready=%b last=%b required 1 0 1 0",
                     b, done, pt_valid, ld_ready, pt_last);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL stream%0d_done_pulse: done=%b required 0", b, done);
        end
    endtask

    task automatic test_backpressure();
        int emit = 0, hs = 0, dn = 0;
        bit hold = 0;
        logic [5:0] sx = '0, sy = '0;
        logic [2:0] sidx = '0;
        pt_ready = 1'b0;
        do_load(0, 0);
        for (int c = 0; c < 20; c++) begin
            if (pt_valid) begin
                if (hold) begin
                    checks++;
                    if (pt_x !== sx || pt_y !== sy || pt_idx !== sidx) begin
                        errors++;
                        $display("FAIL bp_hold c%0d: x=%0d y=%0d idx=%0d required %0d %0d %0d",
                                 c, pt_x, pt_y, pt_idx, sx, sy, sidx);
                    end
                end
                pt_ready = emit[0];
                emit++;
                if (pt_ready) begin
                    checks++;
                    if (hs > 7 || pt_idx !== 3'(hs) || pt_x !== exp_x[0][hs & 7]) begin
                        errors++;
                        $display("FAIL bp_hs%0d: idx=%0d x=%0d required %0d %0d", hs, pt_idx, pt_x, hs, exp_x[0][hs & 7]);
                    end
                    hs++;
                end
                hold = !pt_ready;
                sx = pt_x; sy = pt_y; sidx = pt_idx;
            end else begin
                pt_ready = 1'b0;
                hold = 0;
            end
            if (done === 1'b1) dn++;
            tick();
        end
        checks++;
        if (emit != 16 || hs != 8 || dn != 1) begin
            errors++;
            $display("FAIL bp_counts: emit=%0d hs=%0d done=%0d required 16 8 1", emit, hs, dn);
        end
        pt_ready = 1'b1;
    endtask

    task automatic test_load_during_emit();
        pt_ready = 1'b1;
        do_load(0, 1);
        apply(2);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ld_ready !== 1'b0 || pt_valid !== 1'b1 || pt_idx !== 3'(i) ||
                pt_x !== exp_x[0][i] || pt_y !== exp_y[0][i]) begin
                errors++;
                $display("FAIL lde_first_pt%0d: ldr=%b valid=%b idx=%0d x=%0d y=%0d required 0 1 %0d %0d %0d",
                         i, ld_ready, pt_valid, pt_idx, pt_x, pt_y, i, exp_x[0][i], exp_y[0][i]);
            end
            tick();
        end
        checks++;
        if (pt_valid !== 1'b0 || done !== 1'b1 || ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL lde_gap: valid=%b done=%b ld_ready=%b required 0 1 1", pt_valid, done, ld_ready);
        end
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (pt_valid !== 1'b1 || pt_idx !== 3'(i) || pt_x !== exp_x[2][i] ||
                pt_y !== exp_y[2][i] || pt_oob !== exp_o[2][i]) begin
                errors++;
                $display("FAIL lde_second_pt%0d: valid=%b idx=%0d x=%0d y=%0d oob=%b required 1 %0d %0d %0d %b",
                         i, pt_valid, pt_idx, pt_x, pt_y, pt_oob, i, exp_x[2][i], exp_y[2][i], exp_o[2][i]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL lde_second_done: done=%b required 1", done);
        end
        tick();
    endtask

    task automatic test_flush();
        pt_ready = 1'b1;
        do_load(0, 0);
        repeat (3) tick();
        checks++;
        if (pt_idx !== 3'd3 || pt_x !== 6'd13) begin
            errors++;
            $display("FAIL flush_pre: idx=%0d x=%0d required 3 13", pt_idx, pt_x);
        end
        pt_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (pt_valid !== 1'b0 || done !== 1'b0 || ld_ready !== 1'b1 || pt_idx !== 3'd0) begin
            errors++;
            $display("FAIL flush_emit: valid=%b done=%b ld_ready=%b idx=%0d required 0 0 1 0",
                     pt_valid, done, ld_ready, pt_idx);
        end
        apply(2);
        ld_valid = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (pt_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_ld: valid=%b done=%b required 0 0", pt_valid, done);
        end
        tick();
        ld_valid = 1'b0;
        checks++;
        if (pt_valid !== 1'b1 || pt_idx !== 3'd0 || pt_x !== 6'd18 || pt_y !== 6'd16) begin
            errors++;
            $display("FAIL flush_restart: valid=%b idx=%0d x=%0d y=%0d required 1 0 18 16",
                     pt_valid, pt_idx, pt_x, pt_y);
        end
        pt_ready = 1'b1;
        repeat (8) tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL flush_restart_done: done=%b required 1", done);
        end
        tick();
    endtask

    task automatic test_rst();
        pt_ready = 1'b1;
        do_load(0, 0);
        repeat (5) tick();
        checks++;
        if (pt_idx !== 3'd5 || pt_x !== 6'd22) begin
            errors++;
            $display("FAIL rst_pre: idx=%0d x=%0d required 5 22", pt_idx, pt_x);
        end
        pt_ready = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (pt_valid !== 1'b0 || pt_x !== 6'd0 || pt_y !== 6'd0 || pt_idx !== 3'd0 ||
            pt_oob !== 1'b0 || pt_last !== 1'b0 || done !== 1'b0 || ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: valid=%b x=%0d y=%0d idx=%0d oob=%b last=%b done=%b ldr=%b required 0 0 0 0 0 0 0 1",
                     pt_valid, pt_x, pt_y, pt_idx, pt_oob, pt_last, done, ld_ready);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0 || pt_valid !== 1'b0 || ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_after: done=%b valid=%b ld_ready=%b required 0 0 1", done, pt_valid, ld_ready);
        end
    endtask

    initial begin
        init_tables();
        test_reset();
        test_stream(0);
        test_stream(1);
        test_backpressure();
        test_load_during_emit();
        test_flush();
        test_rst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
